// File: rtl/video_modesync_if.sv
// ----------------------------------------------------------------------------
// video_modesync_if
// Bundles the mode-request inputs and the decoded mode outputs of
// video_modesync.
//   master : drives pent_vmode, atm_vmode and frame_start; observes the outputs
//   slave  : the decoder side (video_modesync)
// Signals:
//   pent_vmode[1:0]  pentagon mode request
//   atm_vmode[2:0]   atm mode request
//   frame_start      one-clock strobe at frame start
//   mode_*           registered one-hot mode flags, pixel clock select,
//                    bandwidth code
//   mode_changed     one-clock pulse when a new mode is applied
//   mode_pending     a request differs from the applied mode or is settling
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface video_modesync_if;
   logic [1:0] pent_vmode;
   logic [2:0] atm_vmode;
   logic       frame_start;
   logic       mode_atm_n_pent;
   logic       mode_zx;
   logic       mode_p_16c;
   logic       mode_p_hmclr;
   logic       mode_a_hmclr;
   logic       mode_a_16c;
   logic       mode_a_text;
   logic       mode_undef;
   logic       mode_pixf_14;
   logic [1:0] mode_bw;
   logic       mode_changed;
   logic       mode_pending;

   modport master (
      output pent_vmode, atm_vmode, frame_start,
      input  mode_atm_n_pent, mode_zx, mode_p_16c, mode_p_hmclr, mode_a_hmclr,
             mode_a_16c, mode_a_text, mode_undef, mode_pixf_14, mode_bw,
             mode_changed, mode_pending
   );

   modport slave (
      input  pent_vmode, atm_vmode, frame_start,
      output mode_atm_n_pent, mode_zx, mode_p_16c, mode_p_hmclr, mode_a_hmclr,
             mode_a_16c, mode_a_text, mode_undef, mode_pixf_14, mode_bw,
             mode_changed, mode_pending
   );
endinterface

// File: rtl/video_modesync.sv
// ----------------------------------------------------------------------------
// video_modesync
// Turns the Z80-side pent_vmode/atm_vmode register values into registered
// one-hot mode flags, a pixel-clock select and a bandwidth code. A changed
// request is applied only after it has been stable for STABLE_CYCLES clocks
// and, when SYNC_TO_FRAME=1, only on a frame_start strobe, so the video
// pipeline never sees a glitched or mid-frame mode switch.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active high
//   bus  video_modesync_if.slave: requests in, decoded mode flags out
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module video_modesync #(
   parameter int          STABLE_CYCLES = 4,
   parameter int          CNT_W         = 4,
   parameter bit          SYNC_TO_FRAME = 1'b1,
   parameter logic [2:0]  RST_ATM       = 3'b011,
   parameter logic [1:0]  RST_PENT      = 2'b00
) (
   input  logic             clk,
   input  logic             rst,
   video_modesync_if.slave  bus
);

   localparam logic [4:0]       RST_MODE = {RST_ATM, RST_PENT};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

   typedef struct packed {
      logic       atm_n_pent;
      logic       zx;
      logic       p_16c;
      logic       p_hmclr;
      logic       a_hmclr;
      logic       a_16c;
      logic       a_text;
      logic       undef;
      logic       pixf_14;
      logic [1:0] bw;
   } flags_t;

   typedef enum logic [1:0] {IDLE, PENDING, ARMED} state_t;

   // Mode word layout is {atm[2:0], pent[1:0]}.
   function automatic flags_t decode(input logic [4:0] m);
      flags_t f;
      f = '0;
      case (m[4:2])
         3'b010: begin f.a_hmclr = 1'b1; f.atm_n_pent = 1'b1; f.pixf_14 = 1'b1; f.bw = 2'b01; end
         3'b000: begin f.a_16c   = 1'b1; f.atm_n_pent = 1'b1; f.bw = 2'b01; end
         3'b110: begin f.a_text  = 1'b1; f.atm_n_pent = 1'b1; f.pixf_14 = 1'b1; f.bw = 2'b01; end
         3'b011: begin
            case (m[1:0])
               2'b01:   f.p_hmclr = 1'b1;
               2'b10:   begin f.p_16c = 1'b1; f.bw = 2'b01; end
               default: f.zx = 1'b1;
            endcase
         end
         default: begin f.zx = 1'b1; f.undef = 1'b1; end
      endcase
      return f;
   endfunction

   logic [4:0]       req_p0;
   logic [4:0]       cur, cur_nx;
   logic [4:0]       cand, cand_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   state_t           state, state_nx;
   flags_t           flags_p1, flags_nx;
   logic             changed_p1;
   logic             apply;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_p0     <= RST_MODE;
         cur        <= RST_MODE;
         cand       <= RST_MODE;
         cnt        <= '0;
         state      <= IDLE;
         flags_p1   <= decode(RST_MODE);
         changed_p1 <= 1'b0;
      end else begin
         // input stage: the FSM only ever looks at the registered request
         req_p0     <= {bus.atm_vmode, bus.pent_vmode};
         cur        <= cur_nx;
         cand       <= cand_nx;
         cnt        <= cnt_nx;
         state      <= state_nx;
         // output stage: flags move only on the apply edge
         flags_p1   <= flags_nx;
         changed_p1 <= apply;
      end
   end

   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      cnt_nx   = cnt;
      apply    = 1'b0;
      case (state)
         IDLE: begin
            if (req_p0 != cur) begin
               cand_nx  = req_p0;
               cnt_nx   = CNT_ONE;
               state_nx = PENDING;
            end
         end
         PENDING: begin
            if (req_p0 != cand) begin
               cand_nx = req_p0;
               cnt_nx  = CNT_ONE;
            end else if (cnt == CNT_MAX) begin
               // a request that settled back onto the applied mode is a glitch
               if (cand == cur)        state_nx = IDLE;
               else if (SYNC_TO_FRAME) state_nx = ARMED;
               else                    apply    = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         ARMED: begin
            // a request change beats a simultaneous frame_start
            if (req_p0 != cand) begin
               cand_nx  = req_p0;
               cnt_nx   = CNT_ONE;
               state_nx = PENDING;
            end else if (bus.frame_start) begin
               apply = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (apply) state_nx = IDLE;
      cur_nx   = apply ? cand : cur;
      flags_nx = apply ? decode(cand) : flags_p1;
   end

   assign bus.mode_atm_n_pent = flags_p1.atm_n_pent;
   assign bus.mode_zx         = flags_p1.zx;
   assign bus.mode_p_16c      = flags_p1.p_16c;
   assign bus.mode_p_hmclr    = flags_p1.p_hmclr;
   assign bus.mode_a_hmclr    = flags_p1.a_hmclr;
   assign bus.mode_a_16c      = flags_p1.a_16c;
   assign bus.mode_a_text     = flags_p1.a_text;
   assign bus.mode_undef      = flags_p1.undef;
   assign bus.mode_pixf_14    = flags_p1.pixf_14;
   assign bus.mode_bw         = flags_p1.bw;
   assign bus.mode_changed    = changed_p1;
   assign bus.mode_pending    = (state != IDLE);

endmodule

// File: tb/tb_video_modesync.sv
// ----------------------------------------------------------------------------
// tb_video_modesync
// Drives an unsynchronised (SYNC_TO_FRAME=0) and a frame-synchronised
// (SYNC_TO_FRAME=1) instance with identical stimulus and compares both against
// a run-length reference model: a request is applied once the registered
// request has held one value for STABLE_CYCLES+1 evaluations (plus one more
// evaluation with frame_start when frame-synchronised).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_modesync;
   localparam int         S        = 4;
   localparam logic [4:0] RST_MODE = 5'b011_00;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [2:0] atm  = 3'b011;
   logic [1:0] pent = 2'b00;
   logic       fs   = 1'b0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   video_modesync_if if0();
   video_modesync_if if1();

   assign if0.atm_vmode   = atm;
   assign if0.pent_vmode  = pent;
   assign if0.frame_start = fs;
   assign if1.atm_vmode   = atm;
   assign if1.pent_vmode  = pent;
   assign if1.frame_start = fs;

   video_modesync #(.STABLE_CYCLES(S), .CNT_W(4), .SYNC_TO_FRAME(1'b0),
                    .RST_ATM(3'b011), .RST_PENT(2'b00))
      dut0 (.clk(clk), .rst(rst), .bus(if0));
   video_modesync #(.STABLE_CYCLES(S), .CNT_W(4), .SYNC_TO_FRAME(1'b1),
                    .RST_ATM(3'b011), .RST_PENT(2'b00))
      dut1 (.clk(clk), .rst(rst), .bus(if1));

   wire [10:0] f0 = {if0.mode_atm_n_pent, if0.mode_zx, if0.mode_p_16c, if0.mode_p_hmclr,
                     if0.mode_a_hmclr, if0.mode_a_16c, if0.mode_a_text, if0.mode_undef,
                     if0.mode_pixf_14, if0.mode_bw};
   wire [10:0] f1 = {if1.mode_atm_n_pent, if1.mode_zx, if1.mode_p_16c, if1.mode_p_hmclr,
                     if1.mode_a_hmclr, if1.mode_a_16c, if1.mode_a_text, if1.mode_undef,
                     if1.mode_pixf_14, if1.mode_bw};

   // reference model state, index 0 = unsynchronised, 1 = frame-synchronised
   logic [4:0] m_req  [2];
   logic [4:0] m_cur  [2];
   logic [4:0] m_last [2];
   int         m_run  [2];
   bit         m_dirty[2];
   bit         m_chg  [2];
   bit         m_pend [2];

   // {atm_n_pent, zx, p_16c, p_hmclr, a_hmclr, a_16c, a_text, undef, pixf_14, bw[1:0]}
   function automatic logic [10:0] exp_flags(input logic [4:0] m);
      case (m[4:2])
         3'b010: return 11'b1_0_0_0_1_0_0_0_1_01;
         3'b000: return 11'b1_0_0_0_0_1_0_0_0_01;
         3'b110: return 11'b1_0_0_0_0_0_1_0_1_01;
         3'b011: begin
            if (m[1:0] == 2'b01)      return 11'b0_0_0_1_0_0_0_0_0_00;
            else if (m[1:0] == 2'b10) return 11'b0_0_1_0_0_0_0_0_0_01;
            else                      return 11'b0_1_0_0_0_0_0_0_0_00;
         end
         default: return 11'b0_1_0_0_0_0_0_1_0_00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int k);
      logic [4:0] req;
      bit         apply;
      bit         idle;
      if (rst) begin
         m_cur[k]   = RST_MODE;
         m_last[k]  = RST_MODE;
         m_run[k]   = 0;
         m_dirty[k] = 1'b0;
         m_chg[k]   = 1'b0;
         m_pend[k]  = 1'b0;
         m_req[k]   = RST_MODE;
      end else begin
         req = m_req[k];
         if (req == m_last[k]) m_run[k]++;
         else                  m_run[k] = 1;
         m_last[k] = req;
         apply = 1'b0;
         if (req != m_cur[k]) begin
            m_dirty[k] = 1'b1;
            if (k == 0) apply = (m_run[k] >= S + 1);
            else        apply = fs && (m_run[k] >= S + 2);
         end
         if (apply) m_cur[k] = req;
         idle = apply || (req == m_cur[k] && (!m_dirty[k] || m_run[k] >= S + 1));
         if (idle) m_dirty[k] = 1'b0;
         m_chg[k]  = apply;
         m_pend[k] = !idle;
         m_req[k]  = {atm, pent};
      end
   endtask

   task automatic check_model(input int k);
      chk($sformatf("dut%0d_flags", k), (k == 0) ? f0 : f1, exp_flags(m_cur[k]));
      chk($sformatf("dut%0d_changed", k),
          (k == 0) ? 11'(if0.mode_changed) : 11'(if1.mode_changed), 11'(m_chg[k]));
      chk($sformatf("dut%0d_pending", k),
          (k == 0) ? 11'(if0.mode_pending) : 11'(if1.mode_pending), 11'(m_pend[k]));
   endtask

   task automatic step(input logic [2:0] a, input logic [1:0] p, input logic f, input logic r);
      atm  = a;
      pent = p;
      fs   = f;
      rst  = r;
      @(posedge clk);
      #1;
      model_edge(0);
      model_edge(1);
      check_model(0);
      check_model(1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      logic [2:0] ra;
      logic [1:0] rp;
      int         len;

      // reset
      repeat (3) step(3'b011, 2'b00, 1'b0, 1'b1);
      chk("t1_zx",      11'(if0.mode_zx), 11'd1);
      chk("t1_bw",      11'(if0.mode_bw), 11'd0);
      chk("t1_changed", 11'(if0.mode_changed), 11'd0);
      chk("t1_pending", 11'(if1.mode_pending), 11'd0);

      // unsynchronised apply after STABLE_CYCLES+1 edges
      step(3'b010, 2'b00, 1'b0, 1'b0);
      repeat (4) step(3'b010, 2'b00, 1'b0, 1'b0);
      chk("t2_hold",    11'(if0.mode_a_hmclr), 11'd0);
      step(3'b010, 2'b00, 1'b0, 1'b0);
      chk("t2_ahmclr",  11'(if0.mode_a_hmclr), 11'd1);
      chk("t2_pixf",    11'(if0.mode_pixf_14), 11'd1);
      chk("t2_bw",      11'(if0.mode_bw), 11'd1);
      chk("t2_atm",     11'(if0.mode_atm_n_pent), 11'd1);
      chk("t2_pulse",   11'(if0.mode_changed), 11'd1);
      step(3'b010, 2'b00, 1'b0, 1'b0);
      chk("t2_pulse_end", 11'(if0.mode_changed), 11'd0);
      step(3'b010, 2'b00, 1'b1, 1'b0);
      chk("t2_sync_apply", 11'(if1.mode_a_hmclr), 11'd1);

      // frame-synchronised: waits for frame_start
      repeat (20) step(3'b000, 2'b00, 1'b0, 1'b0);
      chk("t3_wait",    11'(if1.mode_a_16c), 11'd0);
      step(3'b000, 2'b00, 1'b1, 1'b0);
      chk("t3_a16c",    11'(if1.mode_a_16c), 11'd1);
      chk("t3_bw",      11'(if1.mode_bw), 11'd1);
      chk("t3_pulse",   11'(if1.mode_changed), 11'd1);

      // glitch is filtered
      repeat (7) step(3'b011, 2'b00, 1'b0, 1'b0);
      step(3'b011, 2'b00, 1'b1, 1'b0);
      step(3'b011, 2'b00, 1'b0, 1'b0);
      repeat (2) step(3'b110, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(3'b011, 2'b00, 1'b0, 1'b0);
         chk("t4_nopulse", 11'(if0.mode_changed | if1.mode_changed), 11'd0);
      end
      chk("t4_pending", 11'(if0.mode_pending | if1.mode_pending), 11'd0);
      chk("t4_zx",      11'(if0.mode_zx & if1.mode_zx), 11'd1);

      // request change and frame_start together: change wins
      repeat (7) step(3'b011, 2'b10, 1'b0, 1'b0);
      step(3'b011, 2'b01, 1'b0, 1'b0);
      step(3'b011, 2'b01, 1'b1, 1'b0);
      chk("t5_noapply", 11'(if1.mode_p_16c), 11'd0);
      chk("t5_nopulse", 11'(if1.mode_changed), 11'd0);
      chk("t5_pending", 11'(if1.mode_pending), 11'd1);
      repeat (6) step(3'b011, 2'b01, 1'b0, 1'b0);
      step(3'b011, 2'b01, 1'b1, 1'b0);
      chk("t5_phmclr",  11'(if1.mode_p_hmclr), 11'd1);
      chk("t5_pulse",   11'(if1.mode_changed), 11'd1);

      // undefined atm value, then reset while armed
      repeat (7) step(3'b101, 2'b00, 1'b0, 1'b0);
      chk("t6_undef",   11'(if0.mode_undef), 11'd1);
      chk("t6_zx",      11'(if0.mode_zx), 11'd1);
      chk("t6_bw",      11'(if0.mode_bw), 11'd0);
      chk("t6_armed",   11'(if1.mode_pending), 11'd1);
      step(3'b101, 2'b00, 1'b0, 1'b1);
      chk("t6_rst_zx",  11'(if1.mode_zx), 11'd1);
      chk("t6_rst_p16", 11'(if1.mode_p_hmclr), 11'd0);
      chk("t6_rst_pls", 11'(if1.mode_changed), 11'd0);
      chk("t6_rst_pend", 11'(if1.mode_pending), 11'd0);
      chk("t6_rst_d0",  11'(if0.mode_undef), 11'd0);
      step(3'b101, 2'b00, 1'b0, 1'b0);

      // randomized segments
      for (int seg = 0; seg < 60; seg++) begin
         ra  = 3'($urandom_range(0, 7));
         rp  = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 9);
         for (int j = 0; j < len; j++)
            step(ra, rp, ($urandom_range(0, 4) == 0), ($urandom_range(0, 149) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
